booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier; successor to the combinational 256x64 Booth/Wallace multiplier.
- Consumes PP_PER_CYC Booth digits per cycle into a carry-save accumulator, then resolves with one carry-propagate add.
- Adds signed/unsigned mode per transaction, valid/ready handshakes on input and output, and synchronous flush.
- Sits between operand staging and the result FIFO in the wide-arithmetic datapath, trading latency for area.

Parameters:
- A_LEN, 256, multiplicand width.
- B_LEN, 64, multiplier width; must be even, checked at elaboration.
- PP_PER_CYC, 4, Booth digits per cycle; range 1..NDIG, checked at elaboration.
- P_LEN, A_LEN+B_LEN, product width; derived, do not override.
- Derived: NDIG = B_LEN/2+1 (33); NCYC = ceil(NDIG/PP_PER_CYC) (9).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous abort; returns to IDLE.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with A/B.
- A  in  A_LEN  multiplicand.
- B  in  B_LEN  multiplier.
- out_valid  out  1  P valid.
- out_ready  in  1  consumer accepts P.
- P  out  P_LEN  product.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, busy=0, P=0, counter=0, accumulators=0.
- Clock and reset: one clock; reset is asynchronous and active-low.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands.
    - A is extended by 1 bit (sign if is_signed, else 0).
    - B is extended by 2 bits the same way, then a 0 is appended at the LSB.
    - Clear sum/carry accumulators and cnt; go to ACCUM.
  - ACCUM: per cycle, encode digits j=0..PP_PER_CYC-1 from B bits [2j+1:2j-1] of the current B window.
    - Each digit is one of {0,±A,±2A}; the partial product is shifted by 2*(cnt*PP_PER_CYC+j).
    - Compress partial products plus sum/carry through a CSA tree back into sum/carry.
    - Shift the B window right by 2*PP_PER_CYC; cnt++.
    - When cnt == NCYC-1, go to RESOLVE.
    - Digits past NDIG come from sign/zero-extension bits and encode 0; no special case.
  - RESOLVE: P <= sum + (carry<<1); go to DONE.
  - DONE: out_valid=1, P held stable. When out_ready is high, out_valid drops next cycle and state goes to IDLE.
- Arithmetic:
  - All accumulation is modulo 2^P_LEN; bits above P_LEN are discarded.
  - The result is exact: signed gives the two's-complement A*B; unsigned gives the unsigned A*B.
- Latency:
  - Accept edge at cycle 0; ACCUM occupies cycles 1..NCYC; RESOLVE at NCYC+1; out_valid high from NCYC+2 (11 at defaults).
  - Throughput: one product per NCYC+3 cycles with out_ready held high.
- Handshake:
  - in_ready is combinational from state (== IDLE) only; no same-cycle DONE->accept.
  - in_valid is ignored outside IDLE.
  - Operand changes after accept have no effect.
- flush: from any state, go to IDLE next edge, out_valid=0, in_ready=1. flush wins over in_valid and over the out handshake in the same cycle.
- Reset mid-operation: discard the transaction; all outputs take reset values immediately.
- P retains its last value in IDLE until the next RESOLVE overwrites it.

Decomposition:
- Package booth_pkg:
  - State enum (IDLE, ACCUM, RESOLVE, DONE).
  - Booth digit struct {neg, zero, one, two}.
  - Function ncyc(b_len, pp) and constant NDIG.
  - Function booth_decode(3-bit) returning the digit struct.
- Sub-module booth_digit_pp: one digit (3-bit code + extended A) -> P_LEN-bit partial product, already shifted.
  - Instantiated PP_PER_CYC times in a generate loop.
- The CSA tree and the final adder stay inline in the top.

Test Plan:
- Unsigned basic: is_signed=0, A=3, B=5 -> P=15; out_valid rises exactly 11 cycles after the accept edge; busy high in between.
- Sign handling:
  - A=all-ones, B=all-ones, is_signed=1 -> P=1.
  - Same operands, is_signed=0 -> P=2^320-2^256-2^64+1.
  - Signed A=-2^255, B=-2^63 -> P=2^318.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: P stable, in_ready=0, a new in_valid is ignored.
  - Raise out_ready: out_valid=0 and in_ready=1 on the next cycle.
- Abort and reset:
  - Assert flush in the 4th ACCUM cycle -> IDLE next cycle, no out_valid.
  - Separately drop rst_n mid-ACCUM -> out_valid=0, P=0 asynchronously.
  - A subsequent A=7, B=-2 signed transaction -> P=-14.
- Parameter sweep: PP_PER_CYC in {1,4,33}, i.e. NCYC in {33,9,1}, latency = NCYC+2.
  - 10k random signed/unsigned pairs, including 0 and extreme values, match a behavioural A*B.
  - Back-to-back traffic with random out_ready.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, the digit struct and the digit decoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    typedef struct packed {
        logic neg;
        logic zero;
        logic one;
        logic two;
    } booth_digit_t;

    localparam int SHW  = 16;
    localparam int NDIG = 64 / 2 + 1;

    function automatic int ndig(input int b_len);
        return b_len / 2 + 1;
    endfunction

    function automatic int ncyc(input int b_len, input int pp);
        return (b_len / 2 + 1 + pp - 1) / pp;
    endfunction

    function automatic booth_digit_t booth_decode(input logic [2:0] code);
        booth_digit_t d;
        d.neg  = code[2] & ~(code[1] & code[0]);
        d.zero = (code == 3'b000) || (code == 3'b111);
        d.one  = code[1] ^ code[0];
        d.two  = (code == 3'b011) || (code == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth_mul_seq_pp.sv
// One radix-4 Booth digit: 3-bit code and extended multiplicand in,
// shifted two's-complement partial product (modulo 2^P_LEN) out.
module booth_digit_pp
    import booth_pkg::*;
#(
    parameter int A_LEN = 256,
    parameter int P_LEN = 320
) (
    input  logic [2:0]       code,
    input  logic [A_LEN:0]   a_ext,
    input  logic [SHW-1:0]   shamt,
    output logic [P_LEN-1:0] pp
);

    booth_digit_t      d;
    logic [P_LEN-1:0]  a_wide;
    logic [P_LEN-1:0]  mag;
    logic [P_LEN-1:0]  val;

    always_comb begin
        d      = booth_decode(code);
        a_wide = {{(P_LEN - A_LEN - 1){a_ext[A_LEN]}}, a_ext};
        mag    = '0;
        unique case (1'b1)
            d.zero:  mag = '0;
            d.two:   mag = a_wide << 1;
            d.one:   mag = a_wide;
            default: mag = '0;
        endcase
        val = d.neg ? -mag : mag;
        pp  = val << shamt;
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle radix-4 Booth multiplier: PP_PER_CYC digits per cycle into a
// carry-save accumulator, then one carry-propagate add before handing off.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int A_LEN      = 256,
    parameter int B_LEN      = 64,
    parameter int PP_PER_CYC = 4,
    parameter int P_LEN      = A_LEN + B_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [A_LEN-1:0] A,
    input  logic [B_LEN-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_LEN-1:0] P,
    output logic             busy
);

    localparam int ND = ndig(B_LEN);
    localparam int NC = ncyc(B_LEN, PP_PER_CYC);
    localparam int BW = B_LEN + 3;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    if (B_LEN % 2 != 0) begin : g_chk_b
        $error("B_LEN must be even");
    end
    if (PP_PER_CYC < 1 || PP_PER_CYC > ND) begin : g_chk_pp
        $error("PP_PER_CYC out of range 1..NDIG");
    end
    if (P_LEN != A_LEN + B_LEN) begin : g_chk_p
        $error("P_LEN must equal A_LEN+B_LEN");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [A_LEN:0]   a_reg;
    logic [BW-1:0]    win;
    logic [P_LEN-1:0] sum;
    logic [P_LEN-1:0] carry;
    logic [P_LEN-1:0] p_reg;
    logic             ov_reg;

    logic [P_LEN-1:0] pp [PP_PER_CYC];

    for (genvar j = 0; j < PP_PER_CYC; j++) begin : g_pp
        logic [SHW-1:0] shamt;
        assign shamt = SHW'(2 * (int'(cnt) * PP_PER_CYC + j));
        booth_digit_pp #(
            .A_LEN(A_LEN),
            .P_LEN(P_LEN)
        ) u_pp (
            .code (win[2*j+2:2*j]),
            .a_ext(a_reg),
            .shamt(shamt),
            .pp   (pp[j])
        );
    end

    // Carry is stored pre-shift so sum + (carry << 1) is the running value.
    logic [P_LEN-1:0] s_nxt;
    logic [P_LEN-1:0] c_nxt;
    logic [P_LEN-1:0] t;

    always_comb begin
        s_nxt = sum;
        c_nxt = carry << 1;
        t     = '0;
        for (int j = 0; j < PP_PER_CYC; j++) begin
            t     = s_nxt ^ c_nxt ^ pp[j];
            c_nxt = ((s_nxt & c_nxt) | (s_nxt & pp[j]) |
                     (c_nxt & pp[j])) << 1;
            s_nxt = t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            win    <= '0;
            sum    <= '0;
            carry  <= '0;
            p_reg  <= '0;
            ov_reg <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            cnt    <= '0;
            ov_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {is_signed & A[A_LEN-1], A};
                        win   <= {{2{is_signed & B[B_LEN-1]}}, B, 1'b0};
                        sum   <= '0;
                        carry <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum   <= s_nxt;
                    carry <= c_nxt >> 1;
                    win   <= $unsigned($signed(win) >>> (2 * PP_PER_CYC));
                    if (cnt == CW'(NC - 1)) begin
                        state <= RESOLVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESOLVE: begin
                    p_reg  <= sum + (carry << 1);
                    ov_reg <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        ov_reg <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = ov_reg;
    assign P         = p_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomised bench for booth_mul_seq at PP_PER_CYC 4, 1 and 33, compared
// against a plain wide-arithmetic product model.
module tb_booth_mul_seq;

    localparam int AL = 256;
    localparam int BL = 64;
    localparam int PL = 320;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic is_signed = 1'b0;
    logic out_ready = 1'b1;
    logic [AL-1:0] a_in = '0;
    logic [BL-1:0] b_in = '0;

    logic rdy [3];
    logic ov  [3];
    logic bsy [3];
    logic [PL-1:0] p [3];

    int ncyc_of [3] = '{9, 33, 1};
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.PP_PER_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[0]), .is_signed(is_signed),
        .A(a_in), .B(b_in), .out_valid(ov[0]), .out_ready(out_ready),
        .P(p[0]), .busy(bsy[0])
    );

    booth_mul_seq #(.PP_PER_CYC(1)) dut_pp1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[1]), .is_signed(is_signed),
        .A(a_in), .B(b_in), .out_valid(ov[1]), .out_ready(out_ready),
        .P(p[1]), .busy(bsy[1])
    );

    booth_mul_seq #(.PP_PER_CYC(33)) dut_pp33 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[2]), .is_signed(is_signed),
        .A(a_in), .B(b_in), .out_valid(ov[2]), .out_ready(out_ready),
        .P(p[2]), .busy(bsy[2])
    );

    function automatic logic [PL-1:0] ref_mul(input logic [AL-1:0] a,
                                              input logic [BL-1:0] b,
                                              input logic s);
        logic [PL-1:0] ea;
        logic [PL-1:0] eb;
        ea = s ? {{BL{a[AL-1]}}, a} : {{BL{1'b0}}, a};
        eb = s ? {{AL{b[BL-1]}}, b} : {{AL{1'b0}}, b};
        return ea * eb;
    endfunction

    function automatic logic [AL-1:0] rand_a();
        logic [AL-1:0] r;
        for (int i = 0; i < AL / 32; i++) r[i*32+:32] = $urandom;
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = {1'b1, {(AL-1){1'b0}}};
            3: r = {1'b0, {(AL-1){1'b1}}};
            4: r = AL'(1);
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [BL-1:0] rand_b();
        logic [BL-1:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = {1'b1, {(BL-1){1'b0}}};
            3: r = {1'b0, {(BL-1){1'b1}}};
            4: r = BL'(1);
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [AL-1:0] a, input logic [BL-1:0] b,
                         input logic s);
        a_in = a;
        b_in = b;
        is_signed = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int lat, output bit bsy_ok);
        lat = 1;
        bsy_ok = 1'b1;
        while (!ov[0] && lat < 200) begin
            if (!bsy[0]) bsy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = rdy[0] && rdy[1] && rdy[2];
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || rdy[k] !== 1'b1 || bsy[k] !== 1'b0 ||
                p[k] !== '0) begin
                fails++;
                $display("FAIL reset[%0d]: ov=%b rdy=%b busy=%b P=%h want 0 1 0 0",
                         k, ov[k], rdy[k], bsy[k], p[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic();
        int lat;
        bit bok;
        bit ok;
        out_ready = 1'b1;
        wait_idle(ok);
        drive(AL'(3), BL'(5), 1'b0);
        wait_ov(lat, bok);
        tests++;
        if (lat !== 11) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 11", lat);
        end
        tests++;
        if (p[0] !== PL'(15)) begin
            fails++;
            $display("FAIL basic_product: got %h want %h", p[0], PL'(15));
        end
        tests++;
        if (!bok) begin
            fails++;
            $display("FAIL basic_busy: got busy low want high while in flight");
        end
    endtask

    task automatic test_sign();
        logic [AL-1:0] ta [3];
        logic [BL-1:0] tb [3];
        logic          ts [3];
        logic [PL-1:0] te [3];
        int lat;
        bit bok;
        bit ok;
        ta[0] = '1; tb[0] = '1; ts[0] = 1'b1; te[0] = PL'(1);
        ta[1] = '1; tb[1] = '1; ts[1] = 1'b0;
        te[1] = PL'(0) - (PL'(1) << 256) - (PL'(1) << 64) + PL'(1);
        ta[2] = AL'(1) << 255; tb[2] = BL'(1) << 63; ts[2] = 1'b1;
        te[2] = PL'(1) << 318;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_idle(ok);
            drive(ta[i], tb[i], ts[i]);
            wait_ov(lat, bok);
            tests++;
            if (!ov[0] || p[0] !== te[i]) begin
                fails++;
                $display("FAIL sign[%0d]: ov=%b got %h want %h",
                         i, ov[0], p[0], te[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AL-1:0] a;
        logic [BL-1:0] b;
        logic s;
        logic [PL-1:0] exp;
        int lat;
        bit bok;
        bit ok;
        out_ready = 1'b1;
        wait_idle(ok);
        a = rand_a();
        b = rand_b();
        s = 1'($urandom);
        exp = ref_mul(a, b, s);
        out_ready = 1'b0;
        drive(a, b, s);
        wait_ov(lat, bok);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (ov[0] !== 1'b1 || rdy[0] !== 1'b0 || p[0] !== exp) begin
                fails++;
                $display("FAIL bp_hold[%0d]: ov=%b rdy=%b P=%h want 1 0 %h",
                         c, ov[0], rdy[0], p[0], exp);
            end
            in_valid = (c == 1);
            a_in = ~a;
            b_in = ~b;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 ||
            p[0] !== exp) begin
            fails++;
            $display("FAIL bp_release: ov=%b rdy=%b busy=%b P=%h want 0 1 0 %h",
                     ov[0], rdy[0], bsy[0], p[0], exp);
        end
    endtask

    task automatic test_flush();
        bit seen;
        bit ok;
        out_ready = 1'b1;
        wait_idle(ok);
        drive(rand_a(), rand_b(), 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: busy=%b rdy=%b ov=%b want 0 1 0",
                     bsy[0], rdy[0], ov[0]);
        end
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL flush_no_out: got out_valid 1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        bit ok;
        logic [PL-1:0] want;
        out_ready = 1'b1;
        wait_idle(ok);
        drive(rand_a() | AL'(1), rand_b() | BL'(1), 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (ov[0] !== 1'b0 || p[0] !== '0 || bsy[0] !== 1'b0 ||
            rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: ov=%b busy=%b rdy=%b P=%h want 0 0 1 0",
                     ov[0], bsy[0], rdy[0], p[0]);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(AL'(7), BL'(0) - BL'(2), 1'b1);
        wait_ov(lat, bok);
        want = PL'(0) - PL'(14);
        tests++;
        if (!ov[0] || p[0] !== want) begin
            fails++;
            $display("FAIL after_reset: ov=%b got %h want %h", ov[0], p[0], want);
        end
    endtask

    task automatic test_sweep(input int n);
        logic [AL-1:0] a;
        logic [BL-1:0] b;
        logic s;
        logic [PL-1:0] exp;
        logic [PL-1:0] got [3];
        int lt [3];
        bit seen [3];
        bit ok;
        out_ready = 1'b1;
        for (int it = 0; it < n; it++) begin
            wait_idle(ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL sweep_idle: got in_ready low want high");
            end
            a = rand_a();
            b = rand_b();
            s = 1'($urandom);
            exp = ref_mul(a, b, s);
            for (int k = 0; k < 3; k++) begin
                seen[k] = 1'b0;
                lt[k] = 0;
                got[k] = '0;
            end
            drive(a, b, s);
            for (int l = 1; l <= 40; l++) begin
                for (int k = 0; k < 3; k++) begin
                    if (ov[k] && !seen[k]) begin
                        seen[k] = 1'b1;
                        lt[k] = l;
                        got[k] = p[k];
                    end
                end
                @(posedge clk); #1;
            end
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (got[k] !== exp) begin
                    fails++;
                    $display("FAIL sweep_p[%0d] s=%b a=%h b=%h: got %h want %h",
                             k, s, a, b, got[k], exp);
                end
                tests++;
                if (lt[k] !== ncyc_of[k] + 2) begin
                    fails++;
                    $display("FAIL sweep_lat[%0d]: got %0d want %0d",
                             k, lt[k], ncyc_of[k] + 2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PL-1:0] q [$];
        logic [AL-1:0] a;
        logic [BL-1:0] b;
        logic s;
        logic [PL-1:0] held;
        bit acc;
        bit pop;
        int done;
        int cyc;
        bit ok;
        out_ready = 1'b1;
        wait_idle(ok);
        a = rand_a();
        b = rand_b();
        s = 1'($urandom);
        done = 0;
        cyc = 0;
        while (done < 30 && cyc < 3000) begin
            a_in = a;
            b_in = b;
            is_signed = s;
            in_valid = 1'b1;
            out_ready = 1'($urandom);
            acc = rdy[0];
            pop = ov[0] && out_ready;
            held = p[0];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(ref_mul(a, b, s));
                a = rand_a();
                b = rand_b();
                s = 1'($urandom);
            end
            if (pop) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra: got unexpected result %h want none", held);
                end else begin
                    if (held !== q[0]) begin
                        fails++;
                        $display("FAIL b2b_p[%0d]: got %h want %h", done, held, q[0]);
                    end
                    void'(q.pop_front());
                end
                done++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (done < 30) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d results want 30", done);
        end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_sign();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_sweep(300);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
